// File: rtl/sme_match_collector.sv
// sme_match_collector
//   Collects match strobes from a string-matching engine into a 16-entry
//   register FIFO and presents them to a valid/ready consumer. It counts
//   accepted and dropped matches, flags overflow, and signals done once the
//   engine has finished and the FIFO has drained.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   in_valid       match strobe, one match per cycle
//   in_pattern_no  matching pattern index
//   in_match_addr  text address of the match
//   in_finish      end-of-search pulse
//   out_ready      consumer accepts out_data this cycle
//   out_valid      FIFO not empty
//   out_data       {pattern_no, match_addr} at FIFO head (0 when empty)
//   match_count    accepted matches, saturating at 255
//   drop_count     matches lost to a full FIFO, saturating at 255
//   overflow       sticky, set on the first drop
//   done           finish seen and FIFO fully drained
//
// Build option
//   MATCH_DEDUP_EN  when defined, a per-pattern table of the last accepted
//                   address filters repeated matches of the same address.
//
// States
//   COLLECT | accepting matches from the engine
//   DRAIN   | finish seen, inputs ignored, waiting for FIFO to empty
//   DONE    | FIFO empty after finish; left only by reset

module sme_match_collector (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_pattern_no,
    input  logic [11:0] in_match_addr,
    input  logic        in_finish,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [7:0]  match_count,
    output logic [7:0]  drop_count,
    output logic        overflow,
    output logic        done
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] mem [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  count;
    logic [4:0]  count_next;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        candidate;
    logic        filtered;

    assign full      = (count == 5'd16);
    assign out_valid = (count != 5'd0);
    // Storage is not cleared by reset, so mask the head while empty.
    assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
    assign pop       = out_valid & out_ready;

    assign candidate = in_valid & (state == COLLECT) & ~filtered;
    // A pop in the same cycle frees the slot the push needs when full.
    assign push      = candidate & (~full | pop);
    assign drop      = candidate & full & ~pop;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 5'd1;
        else if (pop && !push)
            count_next = count - 5'd1;
    end

`ifdef MATCH_DEDUP_EN
    logic [11:0] dedup_addr [16];
    logic [15:0] dedup_vld;

    assign filtered = dedup_vld[in_pattern_no] &&
                      (dedup_addr[in_pattern_no] == in_match_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dedup_vld <= '0;
        else if (push)
            dedup_vld[in_pattern_no] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            dedup_addr[in_pattern_no] <= in_match_addr;
    end
`else
    assign filtered = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_pattern_no, in_match_addr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 4'd1;
            if (pop)
                rd_ptr <= rd_ptr + 4'd1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= 8'd0;
            drop_count  <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            if (push && match_count != 8'hFF)
                match_count <= match_count + 8'd1;
            if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
            done  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_finish)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Covers both an already-empty FIFO and the final pop.
                    if (count_next == 5'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= COLLECT;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_match_collector.sv
module tb_sme_match_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_pattern_no = 4'd0;
    logic [11:0] in_match_addr = 12'd0;
    logic        in_finish = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  match_count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        done;

    sme_match_collector dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_pattern_no (in_pattern_no),
        .in_match_addr (in_match_addr),
        .in_finish     (in_finish),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .match_count   (match_count),
        .drop_count    (drop_count),
        .overflow      (overflow),
        .done          (done)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: expected FIFO contents plus counters and phase
    // (0 = collecting, 1 = draining after finish, 2 = done).
    logic [15:0] exp_q [$];
    int          occ = 0;
    int          m_match = 0;
    int          m_drop = 0;
    bit          m_ovf = 0;
    int          m_phase = 0;
    bit          m_tv [16];
    logic [11:0] m_tab [16];
    int          uid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        occ = 0;
        m_match = 0;
        m_drop = 0;
        m_ovf = 0;
        m_phase = 0;
        for (int i = 0; i < 16; i++) m_tv[i] = 0;
    endtask

    // Called at posedge+1; drives one cycle of inputs and advances the model
    // across the following rising edge.
    task automatic step(input logic v, input logic [3:0] pn, input logic [11:0] a,
                        input logic f, input logic r);
        bit pop, push, drop, filt;
        in_valid      = v;
        in_pattern_no = pn;
        in_match_addr = a;
        in_finish     = f;
        out_ready     = r;
        pop  = (occ > 0) && r;
        filt = 0;
`ifdef MATCH_DEDUP_EN
        filt = m_tv[pn] && (m_tab[pn] == a);
`endif
        push = v && (m_phase == 0) && !filt && (occ < 16 || pop);
        drop = v && (m_phase == 0) && !filt && (occ == 16) && !pop;
        @(posedge clk);
        if (push) begin
            exp_q.push_back({pn, a});
            m_tv[pn]  = 1;
            m_tab[pn] = a;
            if (m_match < 255) m_match++;
        end
        if (drop) begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1;
        end
        occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
        if (m_phase == 0 && f) m_phase = 1;
        else if (m_phase == 1 && occ == 0) m_phase = 2;
        #1;
    endtask

    task automatic push_uid(input logic r);
        int p;
        p = uid % 16;
        step(1'b1, p[3:0], uid[11:0], 1'b0, r);
        uid++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 12'd0, 1'b0, r);
    endtask

    // Monitor: inputs are stable at the falling edge; pop expectations here.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("pop_on_empty_model", 32'd1, 32'd0);
                else
                    chk("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
            chk("match_count", {24'd0, match_count}, m_match);
            chk("drop_count", {24'd0, drop_count}, m_drop);
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("done", {31'd0, done}, {31'd0, m_phase == 2});
        end
    end

    initial begin
        int pn, ad, vv, rr;
        int budget;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_match_count", {24'd0, match_count}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Three matches with the consumer always ready.
        step(1'b1, 4'd1, 12'h005, 1'b0, 1'b1);
        step(1'b1, 4'd2, 12'h0A0, 1'b0, 1'b1);
        step(1'b1, 4'd1, 12'h7FF, 1'b0, 1'b1);
        idle(3, 1'b1);
        chk("three_match_count", {24'd0, match_count}, 32'd3);

        // Same match twice back-to-back: filtered only in the dedup build.
        step(1'b1, 4'd3, 12'h123, 1'b0, 1'b1);
        step(1'b1, 4'd3, 12'h123, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Overfill with the consumer stalled, then drain.
        for (int i = 0; i < 20; i++) push_uid(1'b0);
        chk("overfill_ovf", {31'd0, overflow}, 32'd1);
        idle(20, 1'b1);

        // Full FIFO with simultaneous push/pop every cycle.
        for (int i = 0; i < 16; i++) push_uid(1'b0);
        for (int i = 0; i < 20; i++) push_uid(1'b1);
        chk("full_stream_occ", occ, 32'd16);
        idle(20, 1'b1);

        // Randomized traffic with a small address set to exercise filtering.
        for (int i = 0; i < 400; i++) begin
            vv = $urandom_range(0, 3);
            pn = $urandom_range(0, 3);
            ad = $urandom_range(0, 3);
            rr = $urandom_range(0, 1);
            step(vv != 0, pn[3:0], ad[11:0], 1'b0, rr[0]);
        end
        idle(20, 1'b1);

        // Counter saturation.
        for (int i = 0; i < 270; i++) push_uid(1'b1);
        for (int i = 0; i < 280; i++) push_uid(1'b0);
        chk("sat_match", {24'd0, match_count}, 32'd255);
        chk("sat_drop", {24'd0, drop_count}, 32'd255);

        // Asynchronous reset with 8 entries buffered.
        idle(8, 1'b1);
        chk("pre_reset_occ", occ, 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_out_data", {16'd0, out_data}, 32'd0);
        chk("async_match_count", {24'd0, match_count}, 32'd0);
        chk("async_drop_count", {24'd0, drop_count}, 32'd0);
        chk("async_overflow", {31'd0, overflow}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Finish with 5 entries buffered.
        for (int i = 0; i < 5; i++) push_uid(1'b0);
        step(1'b0, 4'd0, 12'd0, 1'b1, 1'b1);
        budget = 0;
        while (m_phase != 2 && budget < 40) begin
            step(1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
            budget++;
        end
        if (budget >= 40) chk("finish_budget", 32'd1, 32'd0);
        chk("finish_pop_cycles", budget, 32'd4);
        chk("finish_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) push_uid(1'b1);
        step(1'b0, 4'd0, 12'd0, 1'b1, 1'b1);
        idle(3, 1'b1);
        chk("post_done_match", {24'd0, match_count}, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
